// File: rtl/mdio_arbiter_if.sv
// Bundle between management clients, the MDIO arbiter and the MDC/MDIO frame generator.
// The arbiter takes the slave modport; whatever drives requests and models the generator takes master.
interface mdio_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [N-1:0]    req_wr;
  logic [5*N-1:0]  req_phy;
  logic [5*N-1:0]  req_reg;
  logic [16*N-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [15:0]     rdata;
  logic            err;
  logic            busy;
  logic            gen_start;
  logic [31:0]     gen_tdata;
  logic [15:0]     gen_rd_data;
  logic            gen_data_rdy;

  modport slave (
    input  req, req_wr, req_phy, req_reg, req_wdata, gen_rd_data, gen_data_rdy,
    output gnt, done, rdata, err, busy, gen_start, gen_tdata
  );

  modport master (
    output req, req_wr, req_phy, req_reg, req_wdata, gen_rd_data, gen_data_rdy,
    input  gnt, done, rdata, err, busy, gen_start, gen_tdata
  );
endinterface

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO frame generator among N management clients.
// Handshake: a client holds req (and its fields) until its one-cycle gnt; done pulses once per granted frame.
module mdio_arbiter #(
  parameter int         N            = 4,
  parameter logic [1:0] OP_RD        = 2'b10,
  parameter logic [1:0] OP_WR        = 2'b01,
  parameter int         START_CLKS   = 4,
  parameter int         WR_CLKS      = 72,
  parameter int         TIMEOUT_CLKS = 96,
  parameter int         GAP_CLKS     = 8
) (
  input  logic              clk,
  input  logic              rst,
  mdio_arbiter_if.slave     bus_if,
  output logic [2:0]        state_o
);

  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int CMAX = (TIMEOUT_CLKS > WR_CLKS) ? TIMEOUT_CLKS : WR_CLKS;
  localparam int CW   = $clog2(CMAX + 1) + 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_q;
  logic            wr_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    gnt_q;
  logic [N-1:0]    done_q;
  logic            err_q;
  logic            busy_q;
  logic            gen_start_q;
  logic [31:0]     tdata_q;
  logic [15:0]     rdata_q;
  logic            rdy_prev_q;

  logic            win_found;
  logic [PW-1:0]   win_idx_d;
  logic            wr_d;
  logic [4:0]      phy_d;
  logic [4:0]      regad_d;
  logic [15:0]     wdata_d;
  logic [31:0]     frame_d;
  logic            rdy_rise;
  int              idx;

  // Scan ptr+1, ptr+2, ... modulo N so the last winner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx_d = '0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!win_found && bus_if.req[PW'(idx)]) begin
        win_found = 1'b1;
        win_idx_d = PW'(idx);
      end
    end
  end

  always_comb begin
    phy_d   = '0;
    regad_d = '0;
    wdata_d = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx_d == PW'(i)) begin
        phy_d   = bus_if.req_phy[5*i +: 5];
        regad_d = bus_if.req_reg[5*i +: 5];
        wdata_d = bus_if.req_wdata[16*i +: 16];
      end
    end
    wr_d    = bus_if.req_wr[win_idx_d];
    frame_d = {2'b01, (wr_d ? OP_WR : OP_RD), phy_d, regad_d,
               (wr_d ? 2'b10 : 2'b00), (wr_d ? wdata_d : 16'h0000)};
  end

  assign rdy_rise = bus_if.gen_data_rdy && !rdy_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= PW'(N - 1);
      win_q       <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      gen_start_q <= 1'b0;
      tdata_q     <= '0;
      rdata_q     <= '0;
      rdy_prev_q  <= 1'b0;
    end else begin
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdy_prev_q <= bus_if.gen_data_rdy;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            gnt_q   <= ONE << win_idx_d;
            ptr_q   <= win_idx_d;
            win_q   <= win_idx_d;
            wr_q    <= wr_d;
            tdata_q <= frame_d;
            busy_q  <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        // One cycle between grant and start keeps gen_start rising the cycle after gnt.
        S_GRANT: begin
          gen_start_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= S_START;
        end
        S_START: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(START_CLKS - 1)) begin
            gen_start_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (wr_q) begin
            if (cnt_q == CW'(WR_CLKS - 1)) begin
              done_q  <= ONE << win_q;
              state_q <= S_DONE;
            end
          end else if (rdy_rise) begin
            rdata_q <= bus_if.gen_rd_data;
            done_q  <= ONE << win_q;
            state_q <= S_DONE;
          end else if (cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
            rdata_q <= 16'hFFFF;
            err_q   <= 1'b1;
            done_q  <= ONE << win_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          state_q <= S_GAP;
        end
        S_GAP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(GAP_CLKS - 1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_if.gnt       = gnt_q;
  assign bus_if.done      = done_q;
  assign bus_if.rdata     = rdata_q;
  assign bus_if.err       = err_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.gen_start = gen_start_q;
  assign bus_if.gen_tdata = tdata_q;
  assign state_o          = state_q;

endmodule
